// File: rtl/mar_burst_ctrl.sv
// ---------------------------------------------------------------------------
// mar_burst_ctrl
//
// Memory address register with explicit load strobes, single-step increment
// and a multi-beat burst engine (incrementing or aligned-wrap addressing).
// The register feeds the memory address bus through a combinational output
// enable (C0).
//
// Ports:
//   i_clk, i_rst_n   clock, asynchronous active-low reset
//   i_mbr_addr/load  load MAR from the MBR path
//   i_pc_addr/load   load MAR from the PC path
//   i_inc            single-step increment by STRIDE
//   i_burst_start    start a burst at the current MAR (IDLE only)
//   i_burst_len      beats in the burst; 0 means "no burst"
//   i_burst_wrap     1 = wrap burst, 0 = incrementing burst (sampled at start)
//   i_beat_ack       memory accepted the current beat
//   i_burst_abort    terminate the burst (wins over i_beat_ack)
//   C0               address bus output enable
//   o_addr           raw MAR contents
//   o_addr_bus       C0 ? MAR : 0
//   o_burst_busy     high while in BURST
//   o_burst_last     high during the final beat of a burst
//
// Handshake: a beat is presented on o_addr while o_burst_busy is high; the
// beat completes on a clock edge where i_beat_ack is high. Without an ack
// (and without an abort) the beat address and beat count hold indefinitely.
// ---------------------------------------------------------------------------
module mar_burst_ctrl #(
    parameter int AW        = 8,
    parameter int LW        = 4,
    parameter int STRIDE    = 1,
    parameter int WRAP_BITS = 2
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic [AW-1:0] i_mbr_addr,
    input  logic          i_mbr_load,
    input  logic [AW-1:0] i_pc_addr,
    input  logic          i_pc_load,
    input  logic          i_inc,
    input  logic          i_burst_start,
    input  logic [LW-1:0] i_burst_len,
    input  logic          i_burst_wrap,
    input  logic          i_beat_ack,
    input  logic          i_burst_abort,
    input  logic          C0,
    output logic [AW-1:0] o_addr,
    output logic [AW-1:0] o_addr_bus,
    output logic          o_burst_busy,
    output logic          o_burst_last
);

    // Step reduced modulo 2^AW.
    localparam logic [AW-1:0] STEP = AW'(STRIDE);
    // Mask selecting the low address bits that wrap in wrap-burst mode.
    // Built by shifting so that WRAP_BITS == AW yields all ones.
    localparam logic [AW-1:0] WMASK = {AW{1'b1}} >> (AW - WRAP_BITS);
    localparam logic [LW-1:0] ONE_BEAT = LW'(1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] mar_q, mar_d;
    logic [LW-1:0] beats_left_q, beats_left_d;
    logic          wrap_mode_q, wrap_mode_d;

    logic [AW-1:0] mar_plus_step;
    logic [AW-1:0] mar_wrap_step;
    logic          burst_go;

    assign mar_plus_step = mar_q + STEP;
    // Only the masked low bits advance; the block base stays fixed.
    assign mar_wrap_step = (mar_q & ~WMASK) | (mar_plus_step & WMASK);
    // A zero-length start request is treated as no request at all.
    assign burst_go      = i_burst_start && (i_burst_len != '0);

    always_comb begin
        state_d      = state_q;
        mar_d        = mar_q;
        beats_left_d = beats_left_q;
        wrap_mode_d  = wrap_mode_q;

        unique case (state_q)
            ST_IDLE: begin
                if (burst_go) begin
                    state_d      = ST_BURST;
                    beats_left_d = i_burst_len;
                    wrap_mode_d  = i_burst_wrap;
                end else if (i_inc) begin
                    mar_d = mar_plus_step;
                end else if (i_mbr_load) begin
                    mar_d = i_mbr_addr;
                end else if (i_pc_load) begin
                    mar_d = i_pc_addr;
                end
            end
            ST_BURST: begin
                if (i_burst_abort) begin
                    state_d      = ST_IDLE;
                    beats_left_d = '0;
                end else if (i_beat_ack) begin
                    mar_d        = wrap_mode_q ? mar_wrap_step : mar_plus_step;
                    beats_left_d = beats_left_q - ONE_BEAT;
                    if (beats_left_q == ONE_BEAT) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= ST_IDLE;
            mar_q        <= '0;
            beats_left_q <= '0;
            wrap_mode_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            mar_q        <= mar_d;
            beats_left_q <= beats_left_d;
            wrap_mode_q  <= wrap_mode_d;
        end
    end

    assign o_addr       = mar_q;
    assign o_addr_bus   = C0 ? mar_q : '0;
    assign o_burst_busy = (state_q == ST_BURST);
    assign o_burst_last = (state_q == ST_BURST) && (beats_left_q == ONE_BEAT);

endmodule

// File: tb/tb_mar_burst_ctrl.sv
module tb_mar_burst_ctrl;

    localparam int AW = 8;
    localparam int LW = 4;

    logic          i_clk;
    logic          i_rst_n;
    logic [AW-1:0] i_mbr_addr;
    logic          i_mbr_load;
    logic [AW-1:0] i_pc_addr;
    logic          i_pc_load;
    logic          i_inc;
    logic          i_burst_start;
    logic [LW-1:0] i_burst_len;
    logic          i_burst_wrap;
    logic          i_beat_ack;
    logic          i_burst_abort;
    logic          C0;
    logic [AW-1:0] o_addr;
    logic [AW-1:0] o_addr_bus;
    logic          o_burst_busy;
    logic          o_burst_last;

    int n_tests = 0;
    int n_fail  = 0;

    mar_burst_ctrl #(
        .AW(AW), .LW(LW), .STRIDE(1), .WRAP_BITS(2)
    ) dut (
        .i_clk(i_clk),
        .i_rst_n(i_rst_n),
        .i_mbr_addr(i_mbr_addr),
        .i_mbr_load(i_mbr_load),
        .i_pc_addr(i_pc_addr),
        .i_pc_load(i_pc_load),
        .i_inc(i_inc),
        .i_burst_start(i_burst_start),
        .i_burst_len(i_burst_len),
        .i_burst_wrap(i_burst_wrap),
        .i_beat_ack(i_beat_ack),
        .i_burst_abort(i_burst_abort),
        .C0(C0),
        .o_addr(o_addr),
        .o_addr_bus(o_addr_bus),
        .o_burst_busy(o_burst_busy),
        .o_burst_last(o_burst_last)
    );

    // ---------------- clock ----------------
    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // ---------------- driver tasks ----------------
    task automatic clear_strobes();
        i_mbr_load    = 1'b0;
        i_pc_load     = 1'b0;
        i_inc         = 1'b0;
        i_burst_start = 1'b0;
        i_beat_ack    = 1'b0;
        i_burst_abort = 1'b0;
    endtask

    // Advance one clock; outputs are sampled 1ns after the edge.
    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic pulse_tick();
        tick();
        clear_strobes();
    endtask

    task automatic load_mbr(input logic [AW-1:0] a);
        i_mbr_addr = a;
        i_mbr_load = 1'b1;
        pulse_tick();
    endtask

    task automatic start_burst(input logic [LW-1:0] len, input logic wrap);
        i_burst_start = 1'b1;
        i_burst_len   = len;
        i_burst_wrap  = wrap;
        pulse_tick();
    endtask

    task automatic ack_beat();
        i_beat_ack = 1'b1;
        pulse_tick();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        clear_strobes();
        i_mbr_addr  = '0;
        i_pc_addr   = '0;
        i_burst_len = '0;
        i_burst_wrap = 1'b0;
        C0          = 1'b1;
        i_rst_n     = 1'b0;
        tick();
        tick();
        n_tests++;
        if (o_addr !== 8'h00 || o_addr_bus !== 8'h00 || o_burst_busy !== 1'b0 || o_burst_last !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: addr=%h bus=%h busy=%b last=%b, want 00 00 0 0",
                     o_addr, o_addr_bus, o_burst_busy, o_burst_last);
        end
        i_rst_n = 1'b1;
        tick();
        load_mbr(8'h3C);
        n_tests++;
        if (o_addr !== 8'h3C || o_addr_bus !== 8'h3C) begin
            n_fail++;
            $display("FAIL mbr_load_3c: addr=%h bus=%h, want 3c 3c", o_addr, o_addr_bus);
        end
        C0 = 1'b0;
        #1;
        n_tests++;
        if (o_addr_bus !== 8'h00 || o_addr !== 8'h3C) begin
            n_fail++;
            $display("FAIL c0_off: bus=%h addr=%h, want 00 3c", o_addr_bus, o_addr);
        end
        C0 = 1'b1;
        #1;
        n_tests++;
        if (o_addr_bus !== 8'h3C) begin
            n_fail++;
            $display("FAIL c0_on: bus=%h, want 3c", o_addr_bus);
        end
    endtask

    task automatic test_priority();
        // inc beats both loads
        i_inc = 1'b1;
        i_mbr_load = 1'b1; i_mbr_addr = 8'h10;
        i_pc_load  = 1'b1; i_pc_addr  = 8'h20;
        pulse_tick();
        n_tests++;
        if (o_addr !== 8'h3D) begin
            n_fail++;
            $display("FAIL inc_priority: addr=%h, want 3d", o_addr);
        end
        // MBR beats PC, zero address loads
        i_mbr_load = 1'b1; i_mbr_addr = 8'h00;
        i_pc_load  = 1'b1; i_pc_addr  = 8'h20;
        pulse_tick();
        n_tests++;
        if (o_addr !== 8'h00) begin
            n_fail++;
            $display("FAIL mbr_zero_over_pc: addr=%h, want 00", o_addr);
        end
        // PC alone
        i_pc_load = 1'b1; i_pc_addr = 8'h5A;
        pulse_tick();
        n_tests++;
        if (o_addr !== 8'h5A) begin
            n_fail++;
            $display("FAIL pc_load: addr=%h, want 5a", o_addr);
        end
        // hold with nothing asserted
        tick();
        n_tests++;
        if (o_addr !== 8'h5A) begin
            n_fail++;
            $display("FAIL idle_hold: addr=%h, want 5a", o_addr);
        end
        // increment wraps past all-ones
        load_mbr(8'hFF);
        i_inc = 1'b1;
        pulse_tick();
        n_tests++;
        if (o_addr !== 8'h00) begin
            n_fail++;
            $display("FAIL inc_wrap_ff: addr=%h, want 00", o_addr);
        end
    endtask

    task automatic test_incr_burst();
        logic [AW-1:0] exp_addr[3];
        logic          exp_last[3];
        exp_addr[0] = 8'h40; exp_addr[1] = 8'h41; exp_addr[2] = 8'h42;
        exp_last[0] = 1'b0;  exp_last[1] = 1'b0;  exp_last[2] = 1'b1;
        load_mbr(8'h40);
        start_burst(4'd3, 1'b0);
        for (int i = 0; i < 3; i++) begin
            n_tests++;
            if (o_addr !== exp_addr[i] || o_burst_busy !== 1'b1 || o_burst_last !== exp_last[i]) begin
                n_fail++;
                $display("FAIL incr_beat%0d: addr=%h busy=%b last=%b, want %h 1 %b",
                         i, o_addr, o_burst_busy, o_burst_last, exp_addr[i], exp_last[i]);
            end
            ack_beat();
        end
        n_tests++;
        if (o_addr !== 8'h43 || o_burst_busy !== 1'b0 || o_burst_last !== 1'b0) begin
            n_fail++;
            $display("FAIL incr_done: addr=%h busy=%b last=%b, want 43 0 0",
                     o_addr, o_burst_busy, o_burst_last);
        end
    endtask

    task automatic test_wrap_burst();
        logic [AW-1:0] exp_addr[4];
        exp_addr[0] = 8'h46; exp_addr[1] = 8'h47; exp_addr[2] = 8'h44; exp_addr[3] = 8'h45;
        load_mbr(8'h46);
        start_burst(4'd4, 1'b1);
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if (o_addr !== exp_addr[i] || o_burst_busy !== 1'b1 || o_burst_last !== (i == 3)) begin
                n_fail++;
                $display("FAIL wrap_beat%0d: addr=%h busy=%b last=%b, want %h 1 %b",
                         i, o_addr, o_burst_busy, o_burst_last, exp_addr[i], (i == 3));
            end
            // gap cycle without ack: everything holds
            tick();
            n_tests++;
            if (o_addr !== exp_addr[i] || o_burst_busy !== 1'b1) begin
                n_fail++;
                $display("FAIL wrap_gap%0d: addr=%h busy=%b, want %h 1",
                         i, o_addr, o_burst_busy, exp_addr[i]);
            end
            ack_beat();
        end
        n_tests++;
        if (o_addr !== 8'h46 || o_burst_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL wrap_done: addr=%h busy=%b, want 46 0", o_addr, o_burst_busy);
        end
    endtask

    task automatic test_abort();
        load_mbr(8'h10);
        start_burst(4'd5, 1'b0);
        ack_beat();
        // inc, loads and a new start are ignored while bursting
        i_inc = 1'b1;
        i_mbr_load = 1'b1; i_mbr_addr = 8'hAA;
        i_pc_load  = 1'b1; i_pc_addr  = 8'hBB;
        i_burst_start = 1'b1; i_burst_len = 4'd1;
        pulse_tick();
        n_tests++;
        if (o_addr !== 8'h11 || o_burst_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL burst_ignores_cmds: addr=%h busy=%b, want 11 1", o_addr, o_burst_busy);
        end
        ack_beat();
        i_burst_abort = 1'b1;
        i_beat_ack    = 1'b1;
        pulse_tick();
        n_tests++;
        if (o_addr !== 8'h12 || o_burst_busy !== 1'b0 || o_burst_last !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_over_ack: addr=%h busy=%b last=%b, want 12 0 0",
                     o_addr, o_burst_busy, o_burst_last);
        end
        // back in IDLE, increment works again
        i_inc = 1'b1;
        pulse_tick();
        n_tests++;
        if (o_addr !== 8'h13) begin
            n_fail++;
            $display("FAIL inc_after_abort: addr=%h, want 13", o_addr);
        end
    endtask

    task automatic test_zero_len_and_async_reset();
        i_burst_start = 1'b1; i_burst_len = 4'd0; i_burst_wrap = 1'b0;
        i_pc_load = 1'b1; i_pc_addr = 8'h77;
        pulse_tick();
        n_tests++;
        if (o_addr !== 8'h77 || o_burst_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_len_falls_through: addr=%h busy=%b, want 77 0", o_addr, o_burst_busy);
        end
        start_burst(4'd1, 1'b0);
        n_tests++;
        if (o_burst_busy !== 1'b1 || o_burst_last !== 1'b1 || o_addr !== 8'h77) begin
            n_fail++;
            $display("FAIL single_beat_last: addr=%h busy=%b last=%b, want 77 1 1",
                     o_addr, o_burst_busy, o_burst_last);
        end
        ack_beat();
        start_burst(4'd3, 1'b0);
        ack_beat();
        // mid-cycle, away from any edge
        #3;
        i_rst_n = 1'b0;
        #1;
        n_tests++;
        if (o_addr !== 8'h00 || o_burst_busy !== 1'b0 || o_burst_last !== 1'b0 || o_addr_bus !== 8'h00) begin
            n_fail++;
            $display("FAIL async_reset: addr=%h busy=%b last=%b bus=%h, want 00 0 0 00",
                     o_addr, o_burst_busy, o_burst_last, o_addr_bus);
        end
        tick();
        i_rst_n = 1'b1;
        tick();
        n_tests++;
        if (o_addr !== 8'h00 || o_burst_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset_idle: addr=%h busy=%b, want 00 0", o_addr, o_burst_busy);
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_priority();
        test_incr_burst();
        test_wrap_burst();
        test_abort();
        test_zero_len_and_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global time bound so the run always ends.
    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
